// File: rtl/key_pkg.sv
// Shared definitions for the pushbutton reader: channel FSM state encoding and board clock rate.
package key_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DEB_DOWN = 3'd1;
    localparam logic [2:0] ST_DOWN     = 3'd2;
    localparam logic [2:0] ST_LONG     = 3'd3;
    localparam logic [2:0] ST_DEB_UP   = 3'd4;

    localparam int CLK_HZ = 50000000;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_DEB_DOWN = ST_DEB_DOWN,
        S_DOWN     = ST_DOWN,
        S_LONG     = ST_LONG,
        S_DEB_UP   = ST_DEB_UP
    } key_state_t;

endpackage

// File: rtl/key_channel.sv
// One pushbutton: 2-flop synchronizer, debounce/hold FSM, registered level and event pulses.
// Latency: press/release reported DEB_CYCLES+2 edges after the first raw sample; long press HOLD_CYCLES after press.
// No backpressure: pulses are single-cycle and are never held or queued.
module key_channel
    import key_pkg::*;
#(
    parameter int DEB_CYCLES  = 1000000,
    parameter int HOLD_CYCLES = 50000000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic CLOCK_50,
    input  logic rst,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int DW = $clog2(DEB_CYCLES);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic IDLE_LVL = (ACTIVE_LOW != 0);

    logic          sync1;
    logic          sync2;
    logic          p;
    key_state_t    state;
    logic [DW-1:0] deb_cnt;
    logic [HW-1:0] hold_cnt;
    logic          was_long;

    // Normalise to 1 = pressed regardless of pin polarity.
    assign p = sync2 ^ IDLE_LVL;

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            sync1       <= IDLE_LVL;
            sync2       <= IDLE_LVL;
            state       <= S_IDLE;
            deb_cnt     <= '0;
            hold_cnt    <= '0;
            was_long    <= 1'b0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            sync1       <= key_raw;
            sync2       <= sync1;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (p) begin
                        state   <= S_DEB_DOWN;
                        deb_cnt <= '0;
                    end
                end
                S_DEB_DOWN: begin
                    if (!p) begin
                        state <= S_IDLE;
                    end else if (deb_cnt == DEB_LAST) begin
                        state     <= S_DOWN;
                        key_press <= 1'b1;
                        key_level <= 1'b1;
                        hold_cnt  <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                S_DOWN: begin
                    if (!p) begin
                        state    <= S_DEB_UP;
                        deb_cnt  <= '0;
                        was_long <= 1'b0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state    <= S_LONG;
                        key_long <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                S_LONG: begin
                    if (!p) begin
                        state    <= S_DEB_UP;
                        deb_cnt  <= '0;
                        was_long <= 1'b1;
                    end
                end
                S_DEB_UP: begin
                    // A glitch back to pressed resumes the press; hold_cnt keeps its value.
                    if (p) begin
                        state <= was_long ? S_LONG : S_DOWN;
                    end else if (deb_cnt == DEB_LAST) begin
                        state       <= S_IDLE;
                        key_release <= 1'b1;
                        key_level   <= 1'b0;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/key_input_reader.sv
// DE2 pushbutton reader: N_KEYS independent debounced channels plus an any-press flag.
// Latency: see key_channel; any_press is combinational from the registered press bits.
// No backpressure: all event outputs are single-cycle pulses.
module key_input_reader
    import key_pkg::*;
#(
    parameter int N_KEYS      = 4,
    parameter int DEB_CYCLES  = 1000000,
    parameter int HOLD_CYCLES = 50000000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic [N_KEYS-1:0] KEY,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long,
    output logic              any_press
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_channel #(
            .DEB_CYCLES (DEB_CYCLES),
            .HOLD_CYCLES(HOLD_CYCLES),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .CLOCK_50   (CLOCK_50),
            .rst        (rst),
            .key_raw    (KEY[i]),
            .key_level  (key_level[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i]),
            .key_long   (key_long[i])
        );
    end

    assign any_press = |key_press;

endmodule

// File: tb/tb_key_input_reader.sv
// Directed bench for key_input_reader with DEB_CYCLES=4, HOLD_CYCLES=20, active-low keys.
module tb_key_input_reader;

    logic       CLOCK_50;
    logic       rst;
    logic [3:0] KEY;
    logic [3:0] key_level;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] key_long;
    logic       any_press;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] key;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
        logic [3:0] lng;
        logic       any;
    } vec_t;

    vec_t vecs[$];

    key_input_reader #(
        .N_KEYS     (4),
        .DEB_CYCLES (4),
        .HOLD_CYCLES(20),
        .ACTIVE_LOW (1)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .rst        (rst),
        .KEY        (KEY),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long),
        .any_press  (any_press)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    function automatic vec_t mk(logic [3:0] k, logic [3:0] lvl, logic [3:0] prs,
                                logic [3:0] rel, logic [3:0] lng);
        vec_t v;
        v.key = k;
        v.lvl = lvl;
        v.prs = prs;
        v.rel = rel;
        v.lng = lng;
        v.any = (prs != 4'b0000);
        return v;
    endfunction

    task automatic push(int n, logic [3:0] k, logic [3:0] lvl, logic [3:0] prs,
                        logic [3:0] rel, logic [3:0] lng);
        for (int j = 0; j < n; j++) vecs.push_back(mk(k, lvl, prs, rel, lng));
    endtask

    task automatic check(string name, int idx, vec_t v);
        n_vec++;
        if (key_level !== v.lvl || key_press !== v.prs || key_release !== v.rel ||
            key_long !== v.lng || any_press !== v.any) begin
            n_bad++;
            $display("FAIL %s[%0d] got lvl=%b prs=%b rel=%b lng=%b any=%b, want lvl=%b prs=%b rel=%b lng=%b any=%b",
                     name, idx, key_level, key_press, key_release, key_long, any_press,
                     v.lvl, v.prs, v.rel, v.lng, v.any);
        end
    endtask

    int step_idx = 0;

    // Drive one raw key pattern for one edge, then check outputs just after that edge.
    task automatic cyc(string name, logic [3:0] k, logic [3:0] lvl, logic [3:0] prs,
                       logic [3:0] rel, logic [3:0] lng);
        KEY = k;
        @(posedge CLOCK_50);
        #1;
        check(name, step_idx, mk(k, lvl, prs, rel, lng));
        step_idx++;
    endtask

    initial begin
        rst = 1'b1;
        KEY = 4'b1111;

        // Clean press/release on key 0.
        push(2, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        push(6, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        push(1, 4'b1110, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        push(3, 4'b1110, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        push(6, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        push(1, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        push(3, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // Bounce on key 1, shorter than the debounce window.
        push(3, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        push(8, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // Long press on key 2 held 40 cycles.
        push(6,  4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        push(1,  4'b1011, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
        push(19, 4'b1011, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        push(1,  4'b1011, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
        push(13, 4'b1011, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        push(6,  4'b1111, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        push(1,  4'b1111, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
        push(3,  4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        repeat (3) @(posedge CLOCK_50);
        #1;
        check("reset_state", 0, mk(4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            KEY = vecs[i].key;
            @(posedge CLOCK_50);
            #1;
            check("table", i, vecs[i]);
        end

        // Release glitch on key 0 while in DOWN.
        repeat (6) cyc("glitch", 4'b1110, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        cyc("glitch", 4'b1110, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        cyc("glitch", 4'b1110, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        repeat (2) cyc("glitch", 4'b1111, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        repeat (8) cyc("glitch", 4'b1110, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        repeat (6) cyc("glitch_rel", 4'b1111, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        cyc("glitch_rel", 4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        repeat (2) cyc("glitch_rel", 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Keys 0 and 3 pressed on the same edge.
        repeat (6) cyc("simul", 4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        cyc("simul", 4'b0110, 4'b1001, 4'b1001, 4'b0000, 4'b0000);
        cyc("simul", 4'b0110, 4'b1001, 4'b0000, 4'b0000, 4'b0000);
        repeat (6) cyc("simul_rel", 4'b1111, 4'b1001, 4'b0000, 4'b0000, 4'b0000);
        cyc("simul_rel", 4'b1111, 4'b0000, 4'b0000, 4'b1001, 4'b0000);
        repeat (2) cyc("simul_rel", 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Reset while key 1 is held in DOWN, then re-debounce after reset.
        repeat (6) cyc("rst_mid", 4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        cyc("rst_mid", 4'b1101, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
        repeat (3) cyc("rst_mid", 4'b1101, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
        rst = 1'b1;
        #1;
        check("rst_async", 0, mk(4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        repeat (2) cyc("rst_hold", 4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        rst = 1'b0;
        repeat (6) cyc("rst_after", 4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        cyc("rst_after", 4'b1101, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
        repeat (4) cyc("rst_after", 4'b1101, 4'b0010, 4'b0000, 4'b0000, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/key_input_reader.md
Name: key_input_reader

Overview:
Input-side counterpart to the team's LED/HEX output FSMs on the DE2 board. It reads the raw pushbuttons (KEY, active-low, bouncing) and turns them into clean per-key events for the display and sequencer FSMs: a level, a one-cycle press pulse, a one-cycle release pulse, and a one-cycle long-press pulse. All logic runs in the single CLOCK_50 domain.

Parameters:
N_KEYS, 4, number of key channels (DE2 KEY[3:0])
DEB_CYCLES, 1000000, debounce window in clocks (20 ms at 50 MHz); legal range is 2 or more
HOLD_CYCLES, 50000000, clocks in the stable-down state before key_long fires (1 s); legal range is 2 or more
ACTIVE_LOW, 1, 1 means a raw key reads 0 when pressed; 0 means it reads 1 when pressed

Ports:
CLOCK_50  input  1  system clock, 50 MHz, rising edge
rst  input  1  reset, asynchronous, active-high; driven from SW[0] at top level
KEY  input  N_KEYS  raw asynchronous key pins
key_level  output  N_KEYS  debounced pressed level, 1 = pressed
key_press  output  N_KEYS  one-cycle pulse on each accepted press
key_release  output  N_KEYS  one-cycle pulse on each accepted release
key_long  output  N_KEYS  one-cycle pulse when a press has been held HOLD_CYCLES
any_press  output  1  OR of key_press

Behaviour:
- Clocking and reset: one clock, CLOCK_50. Reset is asynchronous and active-high on rst.
- While rst is high:
  - all outputs are 0;
  - every channel FSM is in IDLE;
  - all counters are 0;
  - the synchronizer flops hold the inactive level (1 if ACTIVE_LOW=1, else 0).
- Per channel, independently:
  - 2-flop synchronizer. p is the synchronized value normalised to 1 = pressed.
- Counters:
  - deb_cnt width is $clog2(DEB_CYCLES); hold_cnt width is $clog2(HOLD_CYCLES).
  - Neither counter wraps. Each is cleared on entry to the states that use it.
- Channel FSM states: IDLE, DEB_DOWN, DOWN, LONG, DEB_UP. There is also a was_long flag.
  - IDLE: p=1 -> DEB_DOWN, deb_cnt=0.
  - DEB_DOWN, p=0 -> IDLE. The bounce is rejected and no output is produced.
  - DEB_DOWN, p=1 and deb_cnt=DEB_CYCLES-1 -> DOWN. key_press pulses, key_level=1, hold_cnt=0.
  - DEB_DOWN otherwise: deb_cnt++.
  - DOWN, p=0 -> DEB_UP, deb_cnt=0, was_long=0.
  - DOWN, p=1 and hold_cnt=HOLD_CYCLES-1 -> LONG. key_long pulses.
  - DOWN otherwise: hold_cnt++.
  - LONG, p=0 -> DEB_UP, deb_cnt=0, was_long=1. key_long never repeats within one press.
  - DEB_UP, p=1 -> back to LONG if was_long, else DOWN. This is a release glitch. hold_cnt is frozen, not cleared; key_level stays 1.
  - DEB_UP, p=0 and deb_cnt=DEB_CYCLES-1 -> IDLE. key_release pulses, key_level=0.
  - DEB_UP otherwise: deb_cnt++.
- Outputs: key_level, key_press, key_release and key_long are registered. any_press is the combinational OR of the registered key_press bits.
- Latency: if the raw pin is first sampled as pressed at edge E and stays pressed, key_press is high for exactly the cycle after edge E+DEB_CYCLES+2. key_level rises on that same edge. Release is symmetric and produces key_release.
- key_long rises on edge (press edge)+HOLD_CYCLES.
- Simultaneous events: channels are fully independent. Several keys may pulse in the same cycle. any_press is a single-cycle pulse in that case.
- Reset mid-operation: outputs clear immediately when rst rises. After rst falls, a key that is still held is re-debounced from IDLE and produces a new key_press. No key_release is generated for the press that the reset interrupted.

Decomposition:
- Shared package key_pkg holds:
  - the state encoding (3-bit localparams ST_IDLE, ST_DEB_DOWN, ST_DOWN, ST_LONG, ST_DEB_UP);
  - CLK_HZ = 50000000.
- Sub-module key_channel: synchronizer, FSM and counters for a single key, with scalar ports. key_input_reader instantiates N_KEYS copies in a generate loop and ORs the press pulses.

Test Plan:
All scenarios use DEB_CYCLES=4 and HOLD_CYCLES=20.
1. Clean press: KEY[0]=0 first sampled at edge E, held -> key_press[0]=1 only in the cycle after E+6; key_level[0]=1 from E+6; no other outputs move.
2. Press bounce: KEY[1]=0 for 3 cycles, then 1 -> key_press[1] and key_level[1] stay 0 throughout.
3. Long press: hold KEY[2]=0 for 40 cycles, then release cleanly -> key_press at E+6; a single key_long at E+26; key_release pulse 6 edges after the first high sample.
4. Release glitch: KEY[0] in DOWN goes high for 2 cycles, then low again -> no key_release, key_level[0] stays 1, a later clean release still reports correctly.
5. Simultaneous: KEY[0] and KEY[3] fall on the same edge -> key_press[0] and key_press[3] pulse in the same cycle; any_press is high for exactly 1 cycle.
6. Reset mid-hold: rst=1 while KEY[1] is in DOWN -> all outputs 0 asynchronously; rst=0 with the key still held -> a new key_press[1] 6 edges after the first post-reset sample, and no key_release.
